// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the fetch-stage program-counter unit.
//   npc_op_t      : 3-bit next-PC operation issued by the decode stage
//   SEQ/BR/J/JR/JAL : operation encodings (unlisted codes behave as SEQ)
//   DEF_RESET_PC  : default PC loaded on reset
//   DEF_EXC_VEC   : default exception handler entry
// -----------------------------------------------------------------------------
package pc_pkg;

   typedef logic [2:0] npc_op_t;

   localparam npc_op_t SEQ = 3'b000;
   localparam npc_op_t BR  = 3'b001;
   localparam npc_op_t J   = 3'b010;
   localparam npc_op_t JR  = 3'b011;
   localparam npc_op_t JAL = 3'b100;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/pc_unit_ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
// Monitoring-only return-address stack with circular storage.
//   clk, reset_n : clock, asynchronous active-low reset
//   push         : push push_data (overwrites the oldest entry when full)
//   pop          : pop the top and compare it against cmp_data
//   push_data    : return address to record
//   cmp_data     : actual return target used for the comparison
//   miss_cnt     : saturating count of mispredicted / empty-stack returns
//   empty        : stack holds no entries
// push and pop are never asserted together by the parent.
// -----------------------------------------------------------------------------
module ras_stack #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   input  logic [WIDTH-1:0] cmp_data,
   output logic [15:0]      miss_cnt,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    top_reg;     // next free slot; top entry sits just below
   logic [PW:0]      count_reg;
   logic [15:0]      miss_reg;
   logic [PW-1:0]    top_idx;
   logic             miss;

   assign top_idx = top_reg - 1'b1;
   // An empty-stack pop has nothing to compare against and is always a miss.
   assign miss    = pop && ((count_reg == '0) || (mem[top_idx] != cmp_data));

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[top_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         top_reg   <= '0;
         count_reg <= '0;
         miss_reg  <= '0;
      end else begin
         if (push) begin
            // When full, top_reg already points at the oldest slot, so the
            // write overwrites it and the pointer simply wraps.
            top_reg <= top_reg + 1'b1;
            if (count_reg != FULL_CNT) begin
               count_reg <= count_reg + 1'b1;
            end
         end else if (pop && (count_reg != '0)) begin
            top_reg   <= top_idx;
            count_reg <= count_reg - 1'b1;
         end
         if (miss && (miss_reg != 16'hFFFF)) begin
            miss_reg <= miss_reg + 1'b1;
         end
      end
   end

   assign miss_cnt = miss_reg;
   assign empty    = (count_reg == '0);

endmodule

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Fetch-stage program counter with next-PC selection for the five-stage MIPS
// pipeline. Optional return-address stack enabled by defining PC_UNIT_RAS_EN.
//   clk, reset_n  : clock, asynchronous active-low reset
//   stall         : hold the fetch PC
//   d_valid       : decode-stage instruction is real (not a bubble)
//   npc_op        : decode-stage control-flow op (pc_pkg encodings)
//   eq            : branch condition for BR
//   d_pc          : PC of the decode-stage instruction
//   imm26         : jump index / branch offset ([15:0])
//   ra            : forwarded rs value, JR target
//   jr_is_ra      : JR source is $31
//   exc_req, eret : exception entry / return (override stall)
//   epc           : ERET return address
//   pc            : registered fetch PC
//   link_addr     : d_pc + 8 (combinational)
//   ras_miss_cnt  : saturating RAS return-misprediction count (0 without RAS)
//   ras_empty     : RAS empty flag (1 without RAS)
// -----------------------------------------------------------------------------
module pc_unit
   import pc_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(DEF_RESET_PC),
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
   parameter int               RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             stall,
   input  logic             d_valid,
   input  npc_op_t          npc_op,
   input  logic             eq,
   input  logic [WIDTH-1:0] d_pc,
   input  logic [25:0]      imm26,
   input  logic [WIDTH-1:0] ra,
   input  logic             jr_is_ra,
   input  logic             exc_req,
   input  logic             eret,
   input  logic [WIDTH-1:0] epc,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] link_addr,
   output logic [15:0]      ras_miss_cnt,
   output logic             ras_empty
);

   localparam logic [WIDTH-1:0] FOUR  = WIDTH'(4);
   localparam logic [WIDTH-1:0] EIGHT = WIDTH'(8);

   logic [WIDTH-1:0] pc_reg;
   logic [WIDTH-1:0] pc_next;
   logic [WIDTH-1:0] seq_pc;
   logic [WIDTH-1:0] d_pc4;
   logic [WIDTH-1:0] br_target;
   logic [WIDTH-1:0] j_target;

   assign seq_pc    = pc_reg + FOUR;
   assign d_pc4     = d_pc + FOUR;
   assign br_target = d_pc4 + {{(WIDTH-18){imm26[15]}}, imm26[15:0], 2'b00};
   assign j_target  = {d_pc4[WIDTH-1:28], imm26, 2'b00};
   assign link_addr = d_pc + EIGHT;

   always_comb begin
      pc_next = seq_pc;
      if (exc_req) begin
         pc_next = EXC_VEC;
      end else if (eret) begin
         pc_next = epc;
      end else if (stall) begin
         pc_next = pc_reg;
      end else if (d_valid) begin
         case (npc_op)
            // Not-taken branch keeps fetching from pc, preserving the delay slot.
            BR:      pc_next = eq ? br_target : seq_pc;
            J, JAL:  pc_next = j_target;
            JR:      pc_next = ra;
            default: pc_next = seq_pc;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_reg <= RESET_PC;
      end else begin
         pc_reg <= pc_next;
      end
   end

   assign pc = pc_reg;

`ifdef PC_UNIT_RAS_EN
   logic ras_upd;
   logic ras_push;
   logic ras_pop;

   // Exception/ERET and stalls suppress RAS activity for the cycle.
   assign ras_upd  = d_valid && !stall && !exc_req && !eret;
   assign ras_push = ras_upd && (npc_op == JAL);
   assign ras_pop  = ras_upd && (npc_op == JR) && jr_is_ra;

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .WIDTH (WIDTH)
   ) u_ras (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (link_addr),
      .cmp_data  (ra),
      .miss_cnt  (ras_miss_cnt),
      .empty     (ras_empty)
   );
`else
   logic unused_ras;
   assign unused_ras   = jr_is_ra ^ RAS_DEPTH[0];
   assign ras_miss_cnt = '0;
   assign ras_empty    = 1'b1;
`endif

endmodule

// File: doc/pc_unit.md
# pc_unit

Fetch-stage program-counter unit for the five-stage MIPS pipeline. Holds the architectural fetch PC and computes the next PC from the decode-stage control-flow decision: sequential, conditional branch, jump, register jump, exception vector, or ERET. It also hosts an optional return-address stack (RAS) that tracks JAL/JR $ra pairs and counts return mispredictions. It sits between the F-stage instruction memory address port and the D-stage comparator/decoder.

## Interface
- `WIDTH`, 32, PC width in bits (≥ 28 + 2).
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `EXC_VEC`, 32'h0000_4180, exception handler entry.
- `RAS_DEPTH`, 4, RAS entries (power of two, ≥ 2).
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard stall; holds the F PC.
- `d_valid`  in  1  D-stage instruction is valid (not a bubble).
- `npc_op`  in  3  D-stage op: 000 SEQ, 001 BR, 010 J, 011 JR, 100 JAL; others = SEQ.
- `eq`  in  1  branch condition result for BR.
- `d_pc`  in  WIDTH  PC of the D-stage instruction.
- `imm26`  in  26  instruction index or offset; BR uses [15:0].
- `ra`  in  WIDTH  forwarded rs value for JR.
- `jr_is_ra`  in  1  JR source register is $31.
- `exc_req`  in  1  take an exception this cycle.
- `eret`  in  1  return from exception.
- `epc`  in  WIDTH  return address for ERET.
- `pc`  out  WIDTH  current fetch PC (registered).
- `link_addr`  out  WIDTH  d_pc + 8, combinational.
- `ras_miss_cnt`  out  16  saturating count of RAS return mispredictions.
- `ras_empty`  out  1  RAS holds no entries.

## Operation
- The next PC is selected by strict priority:
  1. `exc_req` → EXC_VEC.
  2. `eret` → `epc`.
  3. `stall` → hold `pc`.
  4. `d_valid` with a non-SEQ op → redirect.
  5. Otherwise → `pc + 4`.
- Redirect targets, all arithmetic mod 2^WIDTH:
  - BR: eq ? d_pc + 4 + (sext(imm26[15:0]) << 2) : pc + 4.
  - J and JAL: {(d_pc+4)[WIDTH-1:28], imm26, 2'b00}.
  - JR: `ra`.
- A not-taken BR continues sequentially from `pc`. It does not rewind to d_pc, so the delay slot is preserved.
- Exception and ERET override `stall`. The RAS is not modified by exception or ERET.
- RAS, when compiled in, updates only on cycles with `d_valid && !stall && !exc_req && !eret`:
  - JAL pushes `link_addr`. When full, the oldest entry is overwritten, top wraps circularly, and count stays at RAS_DEPTH.
  - JR with `jr_is_ra` pops. If the stack is non-empty and top ≠ `ra`, `ras_miss_cnt` increments, saturating at 16'hFFFF. A pop on an empty stack counts as a miss and leaves the count at 0.
  - No other op touches the RAS.
- The RAS is monitoring-only. The JR target is always `ra`; prediction never changes `pc`.

## Timing
- `pc` updates on every rising edge. Redirect latency is 1 cycle: a D-stage decision in cycle n gives `pc` = target in cycle n+1.
- Asynchronous reset, applied immediately:
  - `pc` = RESET_PC
  - RAS count = 0, `ras_empty` = 1
  - `ras_miss_cnt` = 0
- Reset asserted mid-operation discards pending redirects and RAS contents. The first fetch after release is RESET_PC, on the first edge with `reset_n` high.
- `link_addr` is purely combinational from `d_pc`.
- Simultaneous push and exception in the same cycle: the exception wins and no push occurs.

## Configuration
- `PC_UNIT_RAS_EN` defined: the RAS, `ras_miss_cnt` and `ras_empty` are live as described above.
- `PC_UNIT_RAS_EN` undefined: no RAS storage is built. `ras_miss_cnt` is tied to 0 and `ras_empty` is tied to 1. Next-PC behaviour is identical in both builds.

## Structure
- Shared package `pc_pkg`:
  - `npc_op` encoding as a 3-bit typedef with named constants SEQ, BR, J, JR, JAL.
  - Default RESET_PC and EXC_VEC constants.
- Sub-module `ras_stack`, parametrised by depth and width. It holds circular storage, count, the push/pop/compare logic and the saturating miss counter. It is instantiated only under `PC_UNIT_RAS_EN`.

## Test plan
- Reset then free-run: `reset_n` low → `pc` = 0x3000 immediately. After release, `pc` steps 0x3004, 0x3008, 0x300C.
- Taken branch:
  - Stimulus: d_pc = 0x3004, npc_op = BR, eq = 1, imm = 0xFFFE.
  - Response: next `pc` = 0x3000.
  - Repeat with eq = 0: next `pc` = current `pc` + 4.
- Stall priority:
  - Stimulus: `stall` = 1 with npc_op = J for 3 cycles.
  - Response: `pc` is held. With `stall` = 1 and `exc_req` = 1, `pc` becomes 0x4180 on the next edge.
- JR and ERET:
  - npc_op = JR, ra = 0x3100 → `pc` = 0x3100.
  - `eret` with epc = 0x3010 → `pc` = 0x3010.
- RAS (with macro):
  - Five JALs from d_pc 0x3000, 0x3010, 0x3020, 0x3030, 0x3040.
  - Four JR $ra with ra = 0x3048, 0x3038, 0x3028, 0x3018 → `ras_miss_cnt` = 0.
  - A fifth JR $ra → miss, count = 1, `ras_empty` = 1.
- RAS mismatch: JAL at d_pc 0x3000, then JR $ra with ra = 0x3050 → `ras_miss_cnt` = 1. Without the macro, `ras_miss_cnt` stays 0 throughout.
